// File: rtl/image_accumulator_pkg.sv
// Shared image-path constants, FSM state encoding and width helpers.
package image_accumulator_pkg;

    localparam int unsigned IMAGE_SIZE_DEF = 128;
    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned ACC_W_DEF      = 24;

    typedef enum logic [1:0] {
        idle_s  = 2'd0,
        clear_s = 2'd1,
        accum_s = 2'd2,
        drain_s = 2'd3
    } state_e;

    // Address width needed to cover a square image of the given side length.
    function automatic int unsigned addr_w(input int unsigned side);
        return $clog2(side * side);
    endfunction

endpackage

// File: rtl/image_accumulator_ram.sv
// Simple dual-port synchronous RAM: one registered read port, one write port.
module image_accumulator_ram #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Write and read-first registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/image_accumulator.sv
// Image accumulator: clears, accumulates PE samples per pixel with saturation,
// and serves host reads from a shared RAM read port.
module image_accumulator
    import image_accumulator_pkg::*;
#(
    parameter  int unsigned IMAGE_SIZE = IMAGE_SIZE_DEF,
    parameter  int unsigned DATA_W     = DATA_W_DEF,
    parameter  int unsigned ACC_W      = ACC_W_DEF,
    localparam int unsigned ADDR_W     = addr_w(IMAGE_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     hs_clear,
    input  logic                     ia_kick,
    input  logic                     ia_done,
    input  logic [ADDR_W-1:0]        ia_addr,
    input  logic                     pe_valid,
    input  logic signed [DATA_W-1:0] pe_value,
    output logic                     ia_enable,
    input  logic                     hs_rd_en,
    input  logic [ADDR_W-1:0]        hs_rd_addr,
    output logic signed [ACC_W-1:0]  hs_rd_data,
    output logic                     hs_rd_valid,
    output logic                     busy,
    output logic                     hs_done,
    output logic                     err
);

    localparam int unsigned N_PIX = IMAGE_SIZE * IMAGE_SIZE;
    localparam int unsigned AXW   = ADDR_W + 1;
    localparam int unsigned SUM_W = ACC_W + 1;

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic                      r_drain_cnt;
    logic [ADDR_W-1:0]         r_clr_addr;
    logic                      r_s1_valid;
    logic [ADDR_W-1:0]         r_s1_addr;
    logic signed [DATA_W-1:0]  r_s1_value;
    logic                      r_fwd_hit;
    logic signed [ACC_W-1:0]   r_fwd_data;
    logic                      r_busy;
    logic                      r_hs_done;
    logic                      r_err;
    logic                      r_rd_valid;

    logic                      w_in_idle;
    logic                      w_in_clear;
    logic                      w_in_accum;
    logic                      w_addr_ok;
    logic                      w_accept;
    logic                      w_host_rd;
    logic                      w_clr_last;
    logic                      w_err_set;
    logic signed [ACC_W-1:0]   w_ram_q;
    logic signed [ACC_W-1:0]   w_operand;
    logic signed [SUM_W-1:0]   w_sum_wide;
    logic signed [ACC_W-1:0]   w_sum;
    logic                      w_rd_en;
    logic [ADDR_W-1:0]         w_rd_addr;
    logic                      w_wr_en;
    logic [ADDR_W-1:0]         w_wr_addr;
    logic [ACC_W-1:0]          w_wr_data;

    assign w_in_idle  = (r_state == idle_s);
    assign w_in_clear = (r_state == clear_s);
    assign w_in_accum = (r_state == accum_s);
    assign w_addr_ok  = ({1'b0, ia_addr} < AXW'(N_PIX));
    assign w_accept   = w_in_accum && pe_valid && w_addr_ok;
    assign w_host_rd  = w_in_idle && hs_rd_en;
    assign w_clr_last = (r_clr_addr == ADDR_W'(N_PIX - 1));
    assign w_err_set  = (!w_in_idle && (ia_kick || hs_clear))
                      || (w_in_accum && pe_valid && !w_addr_ok);

    // Next-state logic; a clear request wins over a kick in idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            idle_s: begin
                if (hs_clear) begin
                    w_state_nxt = clear_s;
                end else if (ia_kick) begin
                    w_state_nxt = accum_s;
                end
            end
            clear_s: begin
                if (w_clr_last) begin
                    w_state_nxt = idle_s;
                end
            end
            accum_s: begin
                if (ia_done) begin
                    w_state_nxt = drain_s;
                end
            end
            drain_s: begin
                if (r_drain_cnt) begin
                    w_state_nxt = idle_s;
                end
            end
            default: w_state_nxt = idle_s;
        endcase
    end

    // State register and control flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= idle_s;
            r_drain_cnt <= 1'b0;
            r_clr_addr  <= '0;
            r_s1_valid  <= 1'b0;
            r_fwd_hit   <= 1'b0;
            r_busy      <= 1'b0;
            r_hs_done   <= 1'b0;
            r_err       <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= (r_state == drain_s) && !r_drain_cnt;
            r_clr_addr  <= w_in_clear ? r_clr_addr + 1'b1 : '0;
            r_s1_valid  <= w_accept;
            r_fwd_hit   <= w_accept && r_s1_valid && (ia_addr == r_s1_addr);
            r_busy      <= (w_state_nxt != idle_s);
            r_hs_done   <= (r_state == drain_s) && !r_drain_cnt;
            r_err       <= r_err || w_err_set;
            r_rd_valid  <= w_host_rd;
        end
    end

    // Stage-1 sample capture and the sum written alongside a same-address read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_addr  <= ia_addr;
            r_s1_value <= pe_value;
        end
        r_fwd_data <= w_sum;
    end

    // Stage-2 operand: forwarded sum when the read raced the previous write.
    assign w_operand  = r_fwd_hit ? r_fwd_data : w_ram_q;
    assign w_sum_wide = SUM_W'(w_operand) + SUM_W'(r_s1_value);

    // Clamp to the signed accumulator range instead of wrapping.
    always_comb begin
        w_sum = w_sum_wide[ACC_W-1:0];
        if (w_sum_wide[SUM_W-1] != w_sum_wide[ACC_W-1]) begin
            w_sum = w_sum_wide[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // RAM port muxing: read shared by accumulate and host, write by clear and stage 2.
    assign w_rd_en   = w_accept || w_host_rd;
    assign w_rd_addr = w_in_accum ? ia_addr : hs_rd_addr;
    assign w_wr_en   = reset_n && (w_in_clear || r_s1_valid);
    assign w_wr_addr = w_in_clear ? r_clr_addr : r_s1_addr;
    assign w_wr_data = w_in_clear ? '0 : w_sum;

    image_accumulator_ram #(
        .DEPTH  (N_PIX),
        .ADDR_W (ADDR_W),
        .DATA_W (ACC_W)
    ) u_ram (
        .clk       (clk),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_ram_q),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data)
    );

    assign ia_enable   = w_in_accum;
    assign hs_rd_data  = w_ram_q;
    assign hs_rd_valid = r_rd_valid;
    assign busy        = r_busy;
    assign hs_done     = r_hs_done;
    assign err         = r_err;

endmodule

// File: tb/tb_image_accumulator.sv
// Bench for image_accumulator: 4x4 image plus a 3x3 instance for out-of-range addresses.
module tb_image_accumulator;

    localparam int unsigned IMAGE_SIZE = 4;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ACC_W      = 24;
    localparam int unsigned N_PIX      = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int          ACC_MAX    = 8388607;
    localparam int          ACC_MIN    = -8388608;

    typedef struct {
        int addr;
        int value;
        int exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset_n;
    logic                     hs_clear, ia_kick, ia_done, pe_valid, hs_rd_en;
    logic [ADDR_W-1:0]        ia_addr, hs_rd_addr;
    logic signed [DATA_W-1:0] pe_value;
    logic signed [ACC_W-1:0]  hs_rd_data;
    logic                     ia_enable, hs_rd_valid, busy, hs_done, err;

    logic                     t3_clear, t3_kick, t3_done, t3_valid, t3_rd_en;
    logic [3:0]               t3_addr, t3_rd_addr;
    logic signed [DATA_W-1:0] t3_value;
    logic signed [ACC_W-1:0]  t3_rd_data;
    logic                     t3_enable, t3_rd_valid, t3_busy, t3_hs_done, t3_err;

    image_accumulator #(.IMAGE_SIZE(IMAGE_SIZE), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset_n(reset_n), .hs_clear(hs_clear), .ia_kick(ia_kick),
        .ia_done(ia_done), .ia_addr(ia_addr), .pe_valid(pe_valid), .pe_value(pe_value),
        .ia_enable(ia_enable), .hs_rd_en(hs_rd_en), .hs_rd_addr(hs_rd_addr),
        .hs_rd_data(hs_rd_data), .hs_rd_valid(hs_rd_valid), .busy(busy),
        .hs_done(hs_done), .err(err)
    );

    image_accumulator #(.IMAGE_SIZE(3), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut3 (
        .clk(clk), .reset_n(reset_n), .hs_clear(t3_clear), .ia_kick(t3_kick),
        .ia_done(t3_done), .ia_addr(t3_addr), .pe_valid(t3_valid), .pe_value(t3_value),
        .ia_enable(t3_enable), .hs_rd_en(t3_rd_en), .hs_rd_addr(t3_rd_addr),
        .hs_rd_data(t3_rd_data), .hs_rd_valid(t3_rd_valid), .busy(t3_busy),
        .hs_done(t3_hs_done), .err(t3_err)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int mdl [N_PIX];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input longint x);
        if (x > ACC_MAX) return ACC_MAX;
        if (x < ACC_MIN) return ACC_MIN;
        return int'(x);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_read_chk(input int a, input int exp);
        hs_rd_en   = 1'b1;
        hs_rd_addr = ADDR_W'(a);
        tick();
        hs_rd_en = 1'b0;
        chk("rd_valid", hs_rd_valid, 1);
        chk($sformatf("mem[%0d]", a), hs_rd_data, exp);
    endtask

    task automatic check_mem();
        for (int i = 0; i < N_PIX; i++) host_read_chk(i, mdl[i]);
    endtask

    // Clear pass; optionally fires an illegal kick mid-clear.
    task automatic do_clear(input bit kick_mid);
        int n = 0;
        hs_clear = 1'b1;
        tick();
        hs_clear = 1'b0;
        while (busy && n < 100) begin
            ia_kick = kick_mid && (n == 5);
            n++;
            tick();
        end
        ia_kick = 1'b0;
        chk("clear_busy_cycles", n, 16);
        for (int i = 0; i < N_PIX; i++) mdl[i] = 0;
    endtask

    // One kick..done pass; model applies each sample as a saturating add.
    task automatic run_stream(input int aq[$], input int vq[$], input int gap_pct);
        int idx = 0;
        ia_kick = 1'b1;
        tick();
        ia_kick = 1'b0;
        chk("ia_enable_after_kick", ia_enable, 1);
        while (idx < aq.size()) begin
            hs_rd_en   = 1'b1;
            hs_rd_addr = ADDR_W'(idx);
            if ($urandom_range(99) < gap_pct) begin
                pe_valid = 1'b0;
                ia_done  = 1'b0;
            end else begin
                pe_valid = 1'b1;
                ia_addr  = ADDR_W'(aq[idx]);
                pe_value = DATA_W'(vq[idx]);
                ia_done  = (idx == aq.size() - 1);
                mdl[aq[idx]] = sat(longint'(mdl[aq[idx]]) + vq[idx]);
                idx++;
            end
            tick();
            if (hs_rd_valid !== 1'b0) chk("rd_ignored_in_accum", hs_rd_valid, 0);
        end
        pe_valid = 1'b0;
        ia_done  = 1'b0;
        hs_rd_en = 1'b0;
        chk("hs_done_drain0", hs_done, 0);
        chk("busy_drain0", busy, 1);
        tick();
        chk("hs_done_pulse", hs_done, 1);
        tick();
        chk("hs_done_after", hs_done, 0);
        chk("busy_after_drain", busy, 0);
    endtask

    initial begin
        vec_t tbl [N_PIX];
        int   aq [$];
        int   vq [$];
        int   n;

        reset_n = 1'b0;
        hs_clear = 1'b0; ia_kick = 1'b0; ia_done = 1'b0; pe_valid = 1'b0; hs_rd_en = 1'b0;
        ia_addr = '0; hs_rd_addr = '0; pe_value = '0;
        t3_clear = 1'b0; t3_kick = 1'b0; t3_done = 1'b0; t3_valid = 1'b0; t3_rd_en = 1'b0;
        t3_addr = '0; t3_rd_addr = '0; t3_value = '0;
        repeat (3) tick();

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_ia_enable", ia_enable, 0);
        chk("rst_hs_done", hs_done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", hs_rd_valid, 0);
        reset_n = 1'b1;
        tick();

        // Clear then read back zeros.
        do_clear(1'b0);
        check_mem();

        // Single stream from a vector table: values 1..16 to addresses 0..15.
        for (int i = 0; i < N_PIX; i++) tbl[i] = '{addr: i, value: i + 1, exp: i + 1};
        aq.delete(); vq.delete();
        for (int i = 0; i < N_PIX; i++) begin aq.push_back(tbl[i].addr); vq.push_back(tbl[i].value); end
        run_stream(aq, vq, 0);
        for (int i = 0; i < N_PIX; i++) host_read_chk(tbl[i].addr, tbl[i].exp);

        // Back-to-back same-address hazard.
        do_clear(1'b0);
        aq = '{5, 5, 5};
        vq = '{10, 20, -7};
        run_stream(aq, vq, 0);
        host_read_chk(5, 23);
        check_mem();

        // Positive saturation: preload 8388600 into pixel 3, then +100.
        aq.delete(); vq.delete();
        for (int i = 0; i < 256; i++) begin aq.push_back(3); vq.push_back(32767); end
        aq.push_back(3); vq.push_back(248);
        run_stream(aq, vq, 0);
        host_read_chk(3, 8388600);
        aq = '{3};
        vq = '{100};
        run_stream(aq, vq, 0);
        host_read_chk(3, ACC_MAX);

        // Negative saturation: -32768 x 300 into pixel 2.
        aq.delete(); vq.delete();
        for (int i = 0; i < 300; i++) begin aq.push_back(2); vq.push_back(-32768); end
        run_stream(aq, vq, 10);
        host_read_chk(2, ACC_MIN);
        check_mem();

        // Randomized streams with clustered addresses and idle gaps.
        do_clear(1'b0);
        for (int s = 0; s < 3; s++) begin
            aq.delete(); vq.delete();
            for (int i = 0; i < 40; i++) begin
                aq.push_back($urandom_range(1) ? int'($urandom_range(3)) : int'($urandom_range(15)));
                vq.push_back(int'($urandom_range(65535)) - 32768);
            end
            run_stream(aq, vq, 25);
        end
        check_mem();
        chk("err_clean", err, 0);

        // Illegal kick during clear: err set, clear still completes.
        do_clear(1'b1);
        chk("err_kick_in_clear", err, 1);
        check_mem();

        // Reset mid-run: four samples offered, reset lands on the fourth.
        ia_kick = 1'b1;
        tick();
        ia_kick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pe_valid = 1'b1;
            ia_addr  = ADDR_W'(i);
            pe_value = DATA_W'((i + 1) * 11);
            reset_n  = (i != 3);
            tick();
        end
        pe_valid = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_ia_enable", ia_enable, 0);
        chk("midrst_err", err, 0);
        chk("midrst_hs_done", hs_done, 0);
        chk("midrst_rd_valid", hs_rd_valid, 0);
        reset_n = 1'b1;
        repeat (4) tick();
        mdl[0] = 11;
        mdl[1] = 22;
        check_mem();

        // 3x3 instance: address 9 is out of range and must only raise err.
        t3_clear = 1'b1;
        tick();
        t3_clear = 1'b0;
        n = 0;
        while (t3_busy && n < 100) begin n++; tick(); end
        chk("t3_clear_cycles", n, 9);
        chk("t3_err_before", t3_err, 0);
        t3_kick = 1'b1;
        tick();
        t3_kick  = 1'b0;
        t3_valid = 1'b1; t3_addr = 4'd9; t3_value = 16'sd5;
        tick();
        t3_addr = 4'd4; t3_value = 16'sd7; t3_done = 1'b1;
        tick();
        t3_valid = 1'b0; t3_done = 1'b0;
        repeat (3) tick();
        chk("t3_err_oob", t3_err, 1);
        for (int i = 0; i < 9; i++) begin
            t3_rd_en = 1'b1;
            t3_rd_addr = 4'(i);
            tick();
            t3_rd_en = 1'b0;
            chk("t3_rd_valid", t3_rd_valid, 1);
            chk($sformatf("t3_mem[%0d]", i), t3_rd_data, (i == 4) ? 7 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
